// File: rtl/pipe_alu_pkg.sv
// pipe_alu_pkg: shared types and constants for the pipe_ALU issue controller.
//   - func code constants (ADD, SUB, MUL, SLA)
//   - alu_op_t: the op fields handed to pipe_ALU
//   - state_t: issue controller FSM states
//   - DEFAULT_PIPE_DEPTH: default ALU occupancy in cycles
package pipe_alu_pkg;

    localparam logic [3:0] ADD = 4'd0;
    localparam logic [3:0] SUB = 4'd1;
    localparam logic [3:0] MUL = 4'd2;
    localparam logic [3:0] SLA = 4'd11;

    localparam int unsigned DEFAULT_PIPE_DEPTH = 3;

    typedef struct packed {
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] rd;
        logic [3:0] func;
        logic [7:0] addr;
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/pipe_alu_scoreboard.sv
// pipe_alu_scoreboard: PIPE_DEPTH-stage shift register of {valid, rd} tracking ops in the ALU.
// Ports:
//   clk, reset  - clock (rising edge), asynchronous active-high reset
//   load        - an op is accepted this cycle; stage 0 captures it at the edge
//   load_rd     - destination register of the accepted op
//   pending     - bit r set while any valid stage holds rd == r
//   hold        - pending restricted to stages that are still in flight after the coming
//                 edge; the last stage writes back at that edge, so a consumer accepted on
//                 the same edge already reads the new value
module pipe_alu_scoreboard
    import pipe_alu_pkg::*;
#(
    parameter int unsigned PIPE_DEPTH = DEFAULT_PIPE_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [3:0]  load_rd,
    output logic [15:0] pending,
    output logic [15:0] hold
);

    logic [PIPE_DEPTH-1:0]      valid_q, valid_d;
    logic [PIPE_DEPTH-1:0][3:0] rd_q, rd_d;

    always_comb begin
        valid_d    = valid_q;
        rd_d       = rd_q;
        valid_d[0] = load;
        rd_d[0]    = load_rd;
        for (int i = 1; i < int'(PIPE_DEPTH); i++) begin
            valid_d[i] = valid_q[i-1];
            rd_d[i]    = rd_q[i-1];
        end
    end

    always_comb begin
        pending = '0;
        hold    = '0;
        for (int i = 0; i < int'(PIPE_DEPTH); i++) begin
            if (valid_q[i]) begin
                pending[rd_q[i]] = 1'b1;
            end
        end
        for (int i = 0; i < int'(PIPE_DEPTH) - 1; i++) begin
            if (valid_q[i]) begin
                hold[rd_q[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
        end
    end

endmodule

// File: rtl/pipe_alu_issue_ctrl.sv
// pipe_alu_issue_ctrl: in-order single-issue controller in front of pipe_ALU with RAW
// hazard detection and a drain handshake.
// Ports:
//   clk, reset                        - clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready               - op offer / acceptance (in_ready is combinational)
//   in_rs1, in_rs2, in_rd, in_func    - offered op register fields and function code
//   in_addr                           - offered op memory address
//   rs1, rs2, rd, func, addr          - registered op fields driven to pipe_ALU
//   issue                             - one-cycle strobe: ALU fields hold a new op
//   drain_req / drain_done            - stop accepting and empty the pipe / drained
//   idle                              - no op in flight
//   stall_cnt, issue_cnt              - statistics counters
// Configuration: define PIPE_ALU_ISSUE_STATS_EN to build the saturating statistics
// counters; otherwise both counter ports are tied to zero.
module pipe_alu_issue_ctrl
    import pipe_alu_pkg::*;
#(
    parameter int unsigned PIPE_DEPTH = DEFAULT_PIPE_DEPTH,
    parameter int unsigned STAT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_rs1,
    input  logic [3:0]        in_rs2,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_func,
    input  logic [7:0]        in_addr,
    output logic [3:0]        rs1,
    output logic [3:0]        rs2,
    output logic [3:0]        rd,
    output logic [3:0]        func,
    output logic [7:0]        addr,
    output logic              issue,
    input  logic              drain_req,
    output logic              drain_done,
    output logic              idle,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] issue_cnt
);

    state_t      state_q, state_d;
    alu_op_t     op_q, op_d;
    logic        issue_q, issue_d;
    logic [15:0] pending;
    logic [15:0] hold;
    logic        hazard;
    logic        sb_empty;
    logic        accept;

    pipe_alu_scoreboard #(
        .PIPE_DEPTH (PIPE_DEPTH)
    ) u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .load    (accept),
        .load_rd (in_rd),
        .pending (pending),
        .hold    (hold)
    );

    // Only source operands are checked: writes retire in order, so WAW is safe, and an op
    // is never in the scoreboard while it is itself being offered.
    assign hazard   = hold[in_rs1] | hold[in_rs2];
    // Every valid entry sets some pending bit, so an all-zero mask means nothing in flight.
    assign sb_empty = ~|pending;
    // drain_req wins over a simultaneous offer.
    assign in_ready = !reset && (state_q != DRAIN) && !drain_req && !hazard;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        if (drain_req) begin
            state_d = DRAIN;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) state_d = RUN;
                end
                RUN: begin
                    if (in_valid && hazard)      state_d = STALL;
                    else if (sb_empty && !accept) state_d = IDLE;
                end
                STALL: begin
                    if (sb_empty && !accept) state_d = IDLE;
                    else if (!hazard)        state_d = RUN;
                end
                DRAIN: begin
                    if (sb_empty) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        op_d    = op_q;
        issue_d = accept;
        if (accept) begin
            op_d.rs1  = in_rs1;
            op_d.rs2  = in_rs2;
            op_d.rd   = in_rd;
            op_d.func = in_func;
            op_d.addr = in_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            issue_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            issue_q <= issue_d;
        end
    end

    assign rs1        = op_q.rs1;
    assign rs2        = op_q.rs2;
    assign rd         = op_q.rd;
    assign func       = op_q.func;
    assign addr       = op_q.addr;
    assign issue      = issue_q;
    assign drain_done = (state_q == DRAIN) && sb_empty;
    assign idle       = sb_empty && !issue_q;

`ifdef PIPE_ALU_ISSUE_STATS_EN
    logic [STAT_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        issue_cnt_d = issue_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (accept && (issue_cnt_q != '1)) begin
            issue_cnt_d = issue_cnt_q + STAT_W'(1);
        end
        if ((state_q == STALL) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign issue_cnt = issue_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign issue_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_alu_issue_ctrl.sv
// tb_pipe_alu_issue_ctrl: directed bench for pipe_alu_issue_ctrl (PIPE_DEPTH = 3).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_pipe_alu_issue_ctrl;
    import pipe_alu_pkg::*;

`ifdef PIPE_ALU_ISSUE_STATS_EN
    localparam int unsigned STATS_ON = 1;
`else
    localparam int unsigned STATS_ON = 0;
`endif

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_rs1, in_rs2, in_rd, in_func;
    logic [7:0]  in_addr;
    logic [3:0]  rs1, rs2, rd, func;
    logic [7:0]  addr;
    logic        issue;
    logic        drain_req;
    logic        drain_done;
    logic        idle;
    logic [15:0] stall_cnt;
    logic [15:0] issue_cnt;

    int checks = 0;
    int errors = 0;

    pipe_alu_issue_ctrl #(
        .PIPE_DEPTH (3),
        .STAT_W     (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .in_func    (in_func),
        .in_addr    (in_addr),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .func       (func),
        .addr       (addr),
        .issue      (issue),
        .drain_req  (drain_req),
        .drain_done (drain_done),
        .idle       (idle),
        .stall_cnt  (stall_cnt),
        .issue_cnt  (issue_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] d,
                         input logic [3:0] f, input logic [7:0] a);
        in_valid = 1'b1;
        in_rs1   = r1;
        in_rs2   = r2;
        in_rd    = d;
        in_func  = f;
        in_addr  = a;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        drain_req = 1'b0;
        offer(4'd1, 4'd2, 4'd3, ADD, 8'd4);
        #1;
        // Reset values, with an op offered to show in_ready stays low.
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_issue", 32'(issue), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_drain_done", 32'(drain_done), 32'd0);
        check("rst_fields", {rs1, rs2, rd, func, addr}, 32'd0);
        check("rst_cnts", {stall_cnt, issue_cnt}, 32'd0);

        // Independent back-to-back ops.
        step();
        step();
        reset = 1'b0;
        offer(4'd3, 4'd5, 4'd10, ADD, 8'd125);
        #1 check("b2b_ready_a", 32'(in_ready), 32'd1);
        step();
        check("b2b_issue_a", 32'(issue), 32'd1);
        check("b2b_fields_a", {rs1, rs2, rd, func, addr}, {4'd3, 4'd5, 4'd10, ADD, 8'd125});
        offer(4'd3, 4'd8, 4'd12, MUL, 8'd126);
        #1 check("b2b_ready_b", 32'(in_ready), 32'd1);
        step();
        check("b2b_issue_b", 32'(issue), 32'd1);
        check("b2b_fields_b", {rs1, rs2, rd, func, addr}, {4'd3, 4'd8, 4'd12, MUL, 8'd126});
        in_valid = 1'b0;
        step();
        check("b2b_issue_off", 32'(issue), 32'd0);
        check("b2b_hold_fields", {rs1, rs2, rd, func, addr}, {4'd3, 4'd8, 4'd12, MUL, 8'd126});
        check("b2b_busy1", 32'(idle), 32'd0);
        step();
        check("b2b_busy2", 32'(idle), 32'd0);
        step();
        check("b2b_idle", 32'(idle), 32'd1);
        check("b2b_stall_cnt", 32'(stall_cnt), 32'd0);
        check("b2b_issue_cnt", 32'(issue_cnt), 32'(2 * STATS_ON));

        // RAW hazard: SUB reads rd of ADD.
        pulse_reset();
        offer(4'd3, 4'd5, 4'd10, ADD, 8'd0);
        #1 check("raw_ready_add", 32'(in_ready), 32'd1);
        step();
        check("raw_issue_add", 32'(issue), 32'd1);
        offer(4'd10, 4'd5, 4'd14, SUB, 8'd1);
        #1 check("raw_ready_n1", 32'(in_ready), 32'd0);
        step();
        check("raw_ready_n2", 32'(in_ready), 32'd0);
        check("raw_issue_n2", 32'(issue), 32'd0);
        step();
        check("raw_ready_n3", 32'(in_ready), 32'd1);
        check("raw_issue_n3", 32'(issue), 32'd0);
        step();
        in_valid = 1'b0;
        check("raw_issue_sub", 32'(issue), 32'd1);
        check("raw_fields_sub", {rs1, rs2, rd, func, addr}, {4'd10, 4'd5, 4'd14, SUB, 8'd1});
        check("raw_stall_cnt", 32'(stall_cnt), 32'(2 * STATS_ON));
        check("raw_issue_cnt", 32'(issue_cnt), 32'(2 * STATS_ON));
        step();
        check("raw_stall_cnt_hold", 32'(stall_cnt), 32'(2 * STATS_ON));

        // Drain pulsed one cycle after an accept, with an op offered alongside.
        pulse_reset();
        offer(4'd1, 4'd2, 4'd3, ADD, 8'd9);
        step();
        check("drn_issue_first", 32'(issue), 32'd1);
        drain_req = 1'b1;
        offer(4'd4, 4'd5, 4'd6, SUB, 8'd10);
        #1 check("drn_ready_req", 32'(in_ready), 32'd0);
        step();
        drain_req = 1'b0;
        #1;
        check("drn_no_accept", 32'(issue), 32'd0);
        check("drn_fields_kept", 32'(rs1), 32'd1);
        check("drn_ready_drain", 32'(in_ready), 32'd0);
        check("drn_done_early1", 32'(drain_done), 32'd0);
        step();
        check("drn_done_early2", 32'(drain_done), 32'd0);
        step();
        check("drn_done", 32'(drain_done), 32'd1);
        check("drn_ready_done", 32'(in_ready), 32'd0);
        step();
        check("drn_done_clear", 32'(drain_done), 32'd0);
        check("drn_ready_idle", 32'(in_ready), 32'd1);
        step();
        check("drn_issue_after", 32'(issue), 32'd1);
        check("drn_rd_after", 32'(rd), 32'd6);

        // Reset with two entries in flight (rd 6 and rd 9).
        offer(4'd7, 4'd8, 4'd9, ADD, 8'd11);
        step();
        in_valid = 1'b0;
        check("mid_issue_pre", 32'(issue), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_idle", 32'(idle), 32'd1);
        check("mid_issue", 32'(issue), 32'd0);
        check("mid_rd", 32'(rd), 32'd0);
        offer(4'd6, 4'd9, 4'd1, MUL, 8'd12);
        #1 check("mid_ready_rst", 32'(in_ready), 32'd0);
        step();
        reset = 1'b0;
        #1 check("mid_ready_rel", 32'(in_ready), 32'd1);
        step();
        check("mid_issue_dep", 32'(issue), 32'd1);
        check("mid_fields_dep", {rs1, rs2, rd, func, addr}, {4'd6, 4'd9, 4'd1, MUL, 8'd12});

        // No self-stall, WAW allowed, rs2 hazard still detected.
        in_valid = 1'b0;
        pulse_reset();
        offer(4'd7, 4'd3, 4'd7, SLA, 8'd20);
        #1 check("waw_ready_self", 32'(in_ready), 32'd1);
        step();
        check("waw_issue_sla", 32'(issue), 32'd1);
        check("waw_func_sla", 32'(func), 32'(SLA));
        offer(4'd12, 4'd13, 4'd13, ADD, 8'd21);
        #1 check("waw_ready_2nd", 32'(in_ready), 32'd1);
        step();
        check("waw_issue_2nd", 32'(issue), 32'd1);
        check("waw_fields_2nd", {rs1, rs2, rd, func, addr}, {4'd12, 4'd13, 4'd13, ADD, 8'd21});
        offer(4'd0, 4'd0, 4'd7, SUB, 8'd22);
        #1 check("waw_ready_rd7", 32'(in_ready), 32'd1);
        step();
        check("waw_issue_rd7", 32'(issue), 32'd1);
        offer(4'd0, 4'd13, 4'd2, ADD, 8'd23);
        #1 check("rs2_hazard", 32'(in_ready), 32'd0);
        step();
        in_valid = 1'b0;
        check("rs2_no_issue", 32'(issue), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
